// File: rtl/gray_cap_pkg.sv
// rtl/gray_cap_pkg.sv - shared types and constants for the grayscale frame capture path
package gray_cap_pkg;

    // Default frame geometry and frame-buffer address width.
    localparam int H_RES_DEF    = 320;
    localparam int V_RES_DEF    = 240;
    localparam int ADDR_W_DEF   = 17;
    localparam int FRAME_PIXELS = H_RES_DEF * V_RES_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // Pixels in one frame of the given geometry.
    function automatic int frame_pixels(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

    // The block reports busy in every state except IDLE.
    function automatic logic state_is_busy(input cap_state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/gray_frame_capture_if.sv
// rtl/gray_frame_capture_if.sv - pixel stream, control and frame-buffer write port bundle
//
// slave  : the capture controller (consumes the stream, drives the BRAM port and status)
// master : the environment (converter output, host control, BRAM/status observer)
//
// gray_in/pixel_valid_in/frame_done_in : grayscale stream and frame qualifier
// capture_req/continuous               : host capture control
// bram_we/bram_addr/bram_din           : frame-buffer write port
// busy/capture_done/frame_short/overflow : host status
interface gray_frame_capture_if
    import gray_cap_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [7:0]        gray_in;
    logic              pixel_valid_in;
    logic              frame_done_in;
    logic              capture_req;
    logic              continuous;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_din;
    logic              busy;
    logic              capture_done;
    logic              frame_short;
    logic              overflow;

    modport slave (
        input  gray_in, pixel_valid_in, frame_done_in, capture_req, continuous,
        output bram_we, bram_addr, bram_din, busy, capture_done, frame_short, overflow
    );

    modport master (
        output gray_in, pixel_valid_in, frame_done_in, capture_req, continuous,
        input  bram_we, bram_addr, bram_din, busy, capture_done, frame_short, overflow
    );
endinterface

// File: rtl/frame_edge_det.sv
// rtl/frame_edge_det.sv - start/end-of-frame pulse generator from frame_done_in
//
// clk_in, rst_in_n : pixel clock, synchronous active-low reset
// frame_done_in    : high during vertical blanking
// sof              : frame_done_in fell (previous registered 1, current 0)
// eof              : frame_done_in rose (previous registered 0, current 1)
module frame_edge_det (
    input  logic clk_in,
    input  logic rst_in_n,
    input  logic frame_done_in,
    output logic sof,
    output logic eof
);
    logic fd_d;
    logic fd_q;

    always_comb begin
        fd_d = frame_done_in;
    end

    // Resetting to 0 means a frame already streaming out of reset never
    // produces a start-of-frame; only a later blanking-to-active fall does.
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            fd_q <= 1'b0;
        end else begin
            fd_q <= fd_d;
        end
    end

    assign sof = fd_q & ~frame_done_in;
    assign eof = ~fd_q & frame_done_in;

endmodule

// File: rtl/gray_frame_capture.sv
// rtl/gray_frame_capture.sv - frame capture sequencer driving the frame-buffer BRAM write port
//
// clk_in   : pixel clock, rising edge
// rst_in_n : synchronous active-low reset
// bus      : slave side of gray_frame_capture_if (stream in, control in,
//            BRAM write port out, busy/capture_done/frame_short/overflow out)
module gray_frame_capture
    import gray_cap_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in_n,
    gray_frame_capture_if.slave   bus
);
    localparam int                FRAME_PIX_I = frame_pixels(H_RES, V_RES);
    localparam logic [ADDR_W-1:0] FRAME_PIX   = FRAME_PIX_I[ADDR_W-1:0];

    logic sof;
    logic eof;

    frame_edge_det u_edge (
        .clk_in        (clk_in),
        .rst_in_n      (rst_in_n),
        .frame_done_in (bus.frame_done_in),
        .sof           (sof),
        .eof           (eof)
    );

    cap_state_t        state_d, state_q;
    logic [ADDR_W-1:0] cnt_d, cnt_q;
    logic              pend_d, pend_q;
    logic              bram_we_d, bram_we_q;
    logic [ADDR_W-1:0] bram_addr_d, bram_addr_q;
    logic [7:0]        bram_din_d, bram_din_q;
    logic              busy_d, busy_q;
    logic              capture_done_d, capture_done_q;
    logic              frame_short_d, frame_short_q;
    logic              overflow_d, overflow_q;
    logic              pix_ok;

    assign pix_ok = bus.pixel_valid_in & ~bus.frame_done_in;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_d         = pend_q;
        bram_we_d      = 1'b0;
        bram_addr_d    = bram_addr_q;
        bram_din_d     = bram_din_q;
        capture_done_d = 1'b0;
        frame_short_d  = frame_short_q;
        overflow_d     = overflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.capture_req || bus.continuous) begin
                    state_d       = ST_ARMED;
                    pend_d        = 1'b0;
                    frame_short_d = 1'b0;
                    overflow_d    = 1'b0;
                end
            end

            ST_ARMED: begin
                // Requests while armed carry no extra meaning; one frame is
                // already pending.
                if (sof) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                    // A pixel coincident with the start-of-frame edge is the
                    // first pixel of the frame and lands at address 0.
                    if (pix_ok) begin
                        bram_we_d   = 1'b1;
                        bram_addr_d = '0;
                        bram_din_d  = bus.gray_in;
                        cnt_d       = {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
            end

            ST_CAPTURE: begin
                if (bus.capture_req) begin
                    pend_d = 1'b1;
                end
                if (eof) begin
                    state_d = ST_DONE;
                    if (cnt_q < FRAME_PIX) begin
                        frame_short_d = 1'b1;
                    end
                end else if (pix_ok) begin
                    if (cnt_q < FRAME_PIX) begin
                        bram_we_d   = 1'b1;
                        bram_addr_d = cnt_q;
                        bram_din_d  = bus.gray_in;
                        cnt_d       = cnt_q + 1'b1;
                    end else begin
                        // Counter holds at FRAME_PIX; excess pixels are dropped.
                        overflow_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                capture_done_d = 1'b1;
                pend_d         = 1'b0;
                if (bus.continuous || pend_q || bus.capture_req) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = state_is_busy(state_d);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            pend_q         <= 1'b0;
            bram_we_q      <= 1'b0;
            bram_addr_q    <= '0;
            bram_din_q     <= '0;
            busy_q         <= 1'b0;
            capture_done_q <= 1'b0;
            frame_short_q  <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            bram_we_q      <= bram_we_d;
            bram_addr_q    <= bram_addr_d;
            bram_din_q     <= bram_din_d;
            busy_q         <= busy_d;
            capture_done_q <= capture_done_d;
            frame_short_q  <= frame_short_d;
            overflow_q     <= overflow_d;
        end
    end

    assign bus.bram_we      = bram_we_q;
    assign bus.bram_addr    = bram_addr_q;
    assign bus.bram_din     = bram_din_q;
    assign bus.busy         = busy_q;
    assign bus.capture_done = capture_done_q;
    assign bus.frame_short  = frame_short_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_gray_frame_capture.sv
// tb/tb_gray_frame_capture.sv - self-checking bench for gray_frame_capture (4x2 frames)
module tb_gray_frame_capture;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 17;
    localparam int NPIX = H * V;

    logic clk_in = 1'b0;
    logic rst_in_n;

    always #5 clk_in = ~clk_in;

    gray_frame_capture_if #(.ADDR_W(AW)) bus ();

    gray_frame_capture #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int wr_addr[$];
    int wr_data[$];
    int done_cnt = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;

    always @(posedge clk_in) begin
        cyc++;
        #1;
        if (bus.bram_we === 1'b1) begin
            wr_addr.push_back(int'(bus.bram_addr));
            wr_data.push_back(int'(bus.bram_din));
            last_we_cyc = cyc;
        end
        if (bus.capture_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_req();
        @(negedge clk_in);
        bus.capture_req = 1'b1;
        @(negedge clk_in);
        bus.capture_req = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    // One frame: falling frame_done, npix pixels (optionally with idle gaps),
    // rising frame_done, then blanking. clr_at >= 0 drops continuous at that pixel.
    task automatic drive_frame(input int npix, input int base, input bit gaps, input int clr_at);
        @(negedge clk_in);
        bus.frame_done_in  = 1'b0;
        bus.pixel_valid_in = 1'b0;
        for (int i = 0; i < npix; i++) begin
            @(negedge clk_in);
            bus.gray_in        = 8'((base + i) & 8'hff);
            bus.pixel_valid_in = 1'b1;
            if (i == clr_at) bus.continuous = 1'b0;
            if (gaps) begin
                @(negedge clk_in);
                bus.pixel_valid_in = 1'b0;
            end
        end
        @(negedge clk_in);
        bus.pixel_valid_in = 1'b0;
        bus.frame_done_in  = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic check_writes(input string tag, input int n_exp, input int base);
        check({tag, "_nwrites"}, wr_addr.size(), n_exp);
        for (int i = 0; i < wr_addr.size() && i < n_exp; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
            check($sformatf("%s_data%0d", tag, i), wr_data[i], (base + i) & 8'hff);
        end
    endtask

    typedef struct {
        int n_pix;
        int base;
        bit gaps;
        int exp_writes;
        bit exp_short;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{n_pix: 8,  base: 'h10, gaps: 1'b0, exp_writes: 8, exp_short: 1'b0, exp_ovf: 1'b0};
        vecs[1] = '{n_pix: 5,  base: 'h40, gaps: 1'b0, exp_writes: 5, exp_short: 1'b1, exp_ovf: 1'b0};
        vecs[2] = '{n_pix: 10, base: 'h80, gaps: 1'b0, exp_writes: 8, exp_short: 1'b0, exp_ovf: 1'b1};
        vecs[3] = '{n_pix: 8,  base: 'hfc, gaps: 1'b1, exp_writes: 8, exp_short: 1'b0, exp_ovf: 1'b0};

        rst_in_n           = 1'b0;
        bus.gray_in        = 8'h00;
        bus.pixel_valid_in = 1'b0;
        bus.frame_done_in  = 1'b1;
        bus.capture_req    = 1'b0;
        bus.continuous     = 1'b0;
        repeat (3) @(negedge clk_in);

        check("rst_we",    int'(bus.bram_we), 0);
        check("rst_addr",  int'(bus.bram_addr), 0);
        check("rst_din",   int'(bus.bram_din), 0);
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_done",  int'(bus.capture_done), 0);
        check("rst_short", int'(bus.frame_short), 0);
        check("rst_ovf",   int'(bus.overflow), 0);

        rst_in_n = 1'b1;
        repeat (2) @(negedge clk_in);

        // Single-shot frames from the vector table.
        for (int v = 0; v < 4; v++) begin
            clear_log();
            pulse_req();
            check($sformatf("v%0d_busy_armed", v), int'(bus.busy), 1);
            drive_frame(vecs[v].n_pix, vecs[v].base, vecs[v].gaps, -1);
            check_writes($sformatf("v%0d", v), vecs[v].exp_writes, vecs[v].base);
            check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d_done_after_we", v), int'(done_cyc > last_we_cyc), 1);
            check($sformatf("v%0d_short", v), int'(bus.frame_short), int'(vecs[v].exp_short));
            check($sformatf("v%0d_ovf", v), int'(bus.overflow), int'(vecs[v].exp_ovf));
            check($sformatf("v%0d_idle", v), int'(bus.busy), 0);
        end

        // Arm while a frame is already streaming: that frame must be skipped.
        clear_log();
        @(negedge clk_in);
        bus.frame_done_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            bus.gray_in        = 8'(8'he0 + i);
            bus.pixel_valid_in = 1'b1;
            bus.capture_req    = (i == 2);
        end
        @(negedge clk_in);
        bus.pixel_valid_in = 1'b0;
        bus.capture_req    = 1'b0;
        bus.frame_done_in  = 1'b1;
        repeat (4) @(negedge clk_in);
        check("mid_nowrites", wr_addr.size(), 0);
        check("mid_busy", int'(bus.busy), 1);
        drive_frame(8, 'h20, 1'b0, -1);
        check_writes("mid", 8, 'h20);
        check("mid_done_cnt", done_cnt, 1);
        check("mid_idle", int'(bus.busy), 0);

        // Continuous mode over three frames, dropped during the third.
        clear_log();
        @(negedge clk_in);
        bus.continuous = 1'b1;
        repeat (2) @(negedge clk_in);
        drive_frame(8, 'h30, 1'b0, -1);
        drive_frame(8, 'h50, 1'b0, -1);
        drive_frame(8, 'h70, 1'b0, 4);
        check("cont_done_cnt", done_cnt, 3);
        check("cont_nwrites", wr_addr.size(), 24);
        for (int i = 0; i < wr_addr.size() && i < 24; i++) begin
            int fbase;
            fbase = (i < 8) ? 'h30 : ((i < 16) ? 'h50 : 'h70);
            check($sformatf("cont_addr%0d", i), wr_addr[i], i % 8);
            check($sformatf("cont_data%0d", i), wr_data[i], fbase + (i % 8));
        end
        check("cont_short", int'(bus.frame_short), 0);
        check("cont_idle", int'(bus.busy), 0);

        // Reset in the middle of a capture, then a clean capture.
        clear_log();
        pulse_req();
        @(negedge clk_in);
        bus.frame_done_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            bus.gray_in        = 8'(8'h90 + i);
            bus.pixel_valid_in = 1'b1;
        end
        @(negedge clk_in);
        check("rstmid_prewrites", wr_addr.size(), 3);
        bus.gray_in = 8'h93;
        rst_in_n    = 1'b0;
        @(posedge clk_in);
        #1;
        check("rstmid_we", int'(bus.bram_we), 0);
        check("rstmid_busy", int'(bus.busy), 0);
        @(negedge clk_in);
        rst_in_n           = 1'b1;
        bus.pixel_valid_in = 1'b0;
        bus.frame_done_in  = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rstmid_idle", int'(bus.busy), 0);
        clear_log();
        pulse_req();
        drive_frame(8, 'h60, 1'b0, -1);
        check_writes("rstmid", 8, 'h60);
        check("rstmid_done_cnt", done_cnt, 1);
        check("rstmid_final_idle", int'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gray_frame_capture.md
# gray_frame_capture

Sequencing controller for the grayscale capture path. It takes the 8-bit grayscale stream and its `pixel_valid`/`frame_done` qualifiers from the RGB565-to-gray converter. It decides which frames get captured, in single-shot or continuous mode, and drives the write port of the frame-buffer BRAM with raster-ordered addresses. It reports completion, short frames and overflow to the host logic.

## Interface
- `H_RES`, default 320: active pixels per line.
- `V_RES`, default 240: active lines per frame.
- `ADDR_W`, default 17: BRAM address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES.
- `clk_in`  in  1  pixel-domain clock; all logic is on the rising edge.
- `rst_in_n`  in  1  synchronous, active-low reset.
- `gray_in`  in  8  grayscale pixel from the converter.
- `pixel_valid_in`  in  1  `gray_in` carries a new pixel this cycle.
- `frame_done_in`  in  1  high during vertical blanking, low while a frame is streaming.
- `capture_req`  in  1  one-cycle request pulse to capture the next whole frame.
- `continuous`  in  1  when high, every frame is captured without `capture_req`.
- `bram_we`  out  1  frame-buffer write enable.
- `bram_addr`  out  ADDR_W  write address, raster order, 0 = top-left.
- `bram_din`  out  8  write data.
- `busy`  out  1  a capture is armed or in progress.
- `capture_done`  out  1  one-cycle pulse when a frame completes.
- `frame_short`  out  1  sticky; last frame ended with fewer than H_RES*V_RES pixels.
- `overflow`  out  1  sticky; pixels arrived after H_RES*V_RES were written.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE
  - Go to ARMED on `capture_req` = 1 or `continuous` = 1.
  - On entry to ARMED, clear `frame_short` and `overflow`.
- ARMED
  - Wait for start of frame, defined as `frame_done_in` falling (registered previous value = 1, current = 0).
  - A frame already streaming when the block arms is skipped. Only whole frames are captured.
  - On start of frame, zero the pixel counter and go to CAPTURE.
- CAPTURE
  - Each cycle with `pixel_valid_in` = 1 and `frame_done_in` = 0:
    - if count < H_RES*V_RES: write `gray_in` to address = count, then increment count;
    - otherwise: drop the pixel and set `overflow`.
  - On `frame_done_in` rising: go to DONE. Set `frame_short` if count < H_RES*V_RES.
  - A pixel with `pixel_valid_in` = 1 in the same cycle as `frame_done_in` rising is not written.
- DONE
  - Lasts one cycle and pulses `capture_done`.
  - Next state is ARMED if `continuous` = 1 or a `capture_req` was latched during the capture, otherwise IDLE.
- `capture_req` during ARMED is ignored. During CAPTURE it sets a one-deep pending flag, so at most one further frame is queued.
- Deasserting `continuous` mid-capture finishes the current frame. The block then goes to IDLE unless a request is pending.
- The counter is ADDR_W bits wide and saturates at H_RES*V_RES. It never wraps.
- `busy` = 1 in ARMED, CAPTURE and DONE.

## Timing
- All outputs are registered.
- Reset values: `bram_we` = 0, `bram_addr` = 0, `bram_din` = 0, `busy` = 0, `capture_done` = 0, `frame_short` = 0, `overflow` = 0. State = IDLE, pending flag = 0.
- Latency: a valid pixel sampled at edge N appears on `bram_we`/`bram_addr`/`bram_din` after edge N, i.e. 1 cycle.
- The start-of-frame decision uses the registered `frame_done_in`. The first pixel of a frame may arrive in the cycle right after the falling edge.
- `capture_done` rises 1 cycle after the edge at which `frame_done_in` is sampled high. It follows the last `bram_we` by at least 1 cycle.
- Reset mid-capture: on the next edge, `bram_we` = 0 and the FSM returns to IDLE. Partial frame contents are left in the BRAM.
- `gray_in` is updated upstream on the falling edge, so it is stable at the rising edge. No extra synchronisation is needed.

## Structure
- Package `gray_cap_pkg`:
  - state enum (IDLE, ARMED, CAPTURE, DONE);
  - default `H_RES`/`V_RES`/`ADDR_W` constants;
  - derived constant FRAME_PIXELS = H_RES*V_RES.
- Sub-module `frame_edge_det`: registers `frame_done_in` and outputs `sof` (falling) and `eof` (rising) pulses.
- Counter, FSM and write-port registers live in the top module.

## Test plan
- Reset, then single shot with `H_RES` = 4, `V_RES` = 2:
  - stimulus: `capture_req`, then a full frame of 8 pixels with `gray_in` = 0x10..0x17;
  - response: writes to addresses 0..7 carrying 0x10..0x17, one `capture_done` pulse, flags 0, FSM back in IDLE.
- Arm mid-frame:
  - stimulus: assert `capture_req` while `frame_done_in` = 0 with pixels flowing;
  - response: no writes until the next falling edge of `frame_done_in`, then a complete 8-pixel capture.
- Short frame:
  - stimulus: only 5 valid pixels before `frame_done_in` rises;
  - response: writes to addresses 0..4, `frame_short` = 1, `capture_done` pulses.
- Overflow:
  - stimulus: 10 valid pixels in one frame;
  - response: exactly 8 writes, `overflow` = 1, pixels 9 and 10 never appear on `bram_we`.
- Continuous mode:
  - stimulus: `continuous` = 1 over 3 frames;
  - response: 3 `capture_done` pulses, address restarts at 0 each frame.
  - stimulus: clear `continuous` during frame 3;
  - response: frame 3 completes, then IDLE.
- Reset mid-capture:
  - stimulus: pull `rst_in_n` low after 3 writes;
  - response: `bram_we` = 0 and `busy` = 0 on the next edge; a new `capture_req` afterwards captures a full frame starting at address 0.
